sle_bank_ctrl: RTL and testbench
================================

# sle_bank_ctrl

Upstream control sequencer for a WIDTH-bit register bank built from SLE cells. It accepts one command at a time over a valid/ready handshake and converts it into cycle-accurate D/En/SLn/SD drive for the bank. The supported commands are parallel load, synchronous clear/set, and multi-step serial shift. It keeps a shadow copy of the expected bank contents and can optionally read the bank's Q back to flag a mismatch.

## Interface
Parameters:
- WIDTH, 8, bank width in bits (2..32)
- SD_VAL, 0, value applied to every cell's SD during CLEAR (0 or 1)

Ports:
- clk  input  1  rising-edge clock, shared with the bank
- ALn  input  1  asynchronous active-low reset; the bank's ALn shares it, with bank ADn tied 1, so the bank resets to all-0
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command (high only in IDLE)
- cmd_op  input  2  00 LOAD, 01 CLEAR, 10 SHIFT, 11 NOP
- cmd_data  input  WIDTH  LOAD data; for SHIFT, bits [3:0] are the step count
- ser_in  input  1  serial bit shifted into bit 0 on each SHIFT step, sampled every DRIVE cycle
- q_in  input  WIDTH  bank Q readback
- D  output  WIDTH  bank data inputs
- En  output  1  bank enable
- SLn  output  1  bank synchronous load, active low
- SD  output  1  bank synchronous load data
- done  output  1  one-cycle completion pulse
- err  output  1  readback mismatch; valid while done=1, held until the next done

## Operation
State machine: IDLE, DRIVE, CHECK (CHECK exists only with the macro).

- **IDLE:** cmd_ready=1. The command is accepted on an edge where cmd_valid=1.
- **cmd_valid while cmd_ready=0:** ignored, not queued.
- **Acceptance:**
  - LOAD, CLEAR, and SHIFT with a nonzero count go to DRIVE.
  - NOP, and SHIFT with count 0, stay in IDLE and pulse done next cycle with err=0. The bank is untouched.
- **DRIVE, LOAD:** D=cmd_data (captured at accept), En=1, SLn=1. Shadow becomes cmd_data. Lasts one cycle.
- **DRIVE, CLEAR:** En=1, SLn=0, SD=SD_VAL, D=0. Shadow becomes {WIDTH{SD_VAL}}. Lasts one cycle.
- **DRIVE, SHIFT:** lasts count cycles (1..15). Each cycle D={shadow[WIDTH-2:0], ser_in}, En=1, SLn=1. The shadow updates identically at each edge. A remaining-steps counter decrements per edge.
- **DRIVE exit:** after the last DRIVE edge, go to CHECK (macro defined) or to IDLE with done (macro undefined).
- **CHECK:** drive outputs are idle. At the CHECK edge, err<=(q_in!=shadow), done<=1, and the state returns to IDLE.
- **Idle drive values** (outside DRIVE): En=0, SLn=1, SD=0, D=0.
- **Registration:** all outputs are registered except cmd_ready, which decodes state directly.

## Timing
- **Reset (ALn=0, async):**
  - State IDLE, shadow=0, step counter=0.
  - Outputs: cmd_ready=1, En=0, SLn=1, SD=0, D=0, done=0, err=0.
- **Reset mid-operation:** ALn low in any state aborts immediately. No done is produced for the aborted command.
- **LOAD/CLEAR with check:**
  - Accept at edge E0.
  - DRIVE in cycle C1; the bank captures at E1.
  - CHECK in C2; q_in is sampled at E2.
  - done=1 in C3, where cmd_ready=1 again. Next accept is at E3 at the earliest.
- **SHIFT count n:** done appears n+2 cycles after acceptance with check, n+1 without.
- **Without the macro:** LOAD/CLEAR done is in C2, two cycles after acceptance.
- **NOP / SHIFT count 0:** done in C1.
- **done:** exactly one cycle wide.
- **Back-to-back commands:** a command accepted in the done cycle proceeds normally. The second done comes no earlier than 3 cycles (check) or 2 cycles (no check) later.
- **Shadow bit-drop:** shift steps drop shadow[WIDTH-1].

## Configuration
- Macro: SLE_BANK_CTRL_CHECK_EN.
- **Defined:**
  - The CHECK state and q_in comparison are compiled in.
  - err reports a mismatch.
- **Undefined:**
  - CHECK is removed; DRIVE returns straight to IDLE.
  - q_in is unused, and err is tied to 0.
  - Latency drops by one cycle.

## Test plan
- **Reset mid-SHIFT:** reset, then SHIFT count 15; pull ALn low in the 4th DRIVE cycle -> outputs return to reset values asynchronously, with no done. Next, LOAD 0x5A (with a correct bank model) -> done with err=0.
- **LOAD then CLEAR (WIDTH=8, SD_VAL=0):** LOAD 0xA5 -> D=0xA5, En=1 for exactly one cycle, done 3 cycles after accept, err=0. Then CLEAR -> SLn=0, SD=0 for one cycle, shadow=0x00, err=0.
- **SHIFT:** from shadow 0x81, SHIFT count 3 with ser_in=1,0,1 -> D sequence 0x03, 0x06, 0x0D; done 5 cycles after accept.
- **Zero count, NOP, and ignored command:**
  - SHIFT count 0 -> no En pulse; done next cycle, err=0.
  - NOP -> same response.
  - cmd_valid held during DRIVE -> not accepted until the done cycle.
- **Mismatch:** bank model forces bit 3 stuck at 0; LOAD 0xFF -> done with err=1. Next LOAD 0x00 -> err=0.
- **Macro undefined:** LOAD 0x3C -> done 2 cycles after accept, err=0 even with q_in mismatched.

Source files
------------

// File: rtl/sle_bank_ctrl.sv
// sle_bank_ctrl: command sequencer driving D/En/SLn/SD of an SLE register
// bank; keeps a shadow of the bank and optionally checks Q readback.
//
// Ports: clk, ALn (async active-low reset shared with the bank),
//   cmd_valid/cmd_ready/cmd_op/cmd_data (command handshake),
//   ser_in (serial shift bit), q_in (bank Q readback),
//   D/En/SLn/SD (registered bank drive), done (one-cycle pulse),
//   err (readback mismatch, held until the next done).
// Macro SLE_BANK_CTRL_CHECK_EN compiles in the CHECK state and q_in compare;
// without it err is tied 0 and q_in is unused.
module sle_bank_ctrl #(
  parameter int   WIDTH  = 8,
  parameter logic SD_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             ALn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] D,
  output logic             En,
  output logic             SLn,
  output logic             SD,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_SHIFT = 2'b10;

`ifdef SLE_BANK_CTRL_CHECK_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_CHECK
  } state_e;
`else
  typedef enum logic [0:0] {
    S_IDLE,
    S_DRIVE
  } state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             en_q, en_d;
  logic             sln_q, sln_d;
  logic             sd_q, sd_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] shift_val;
  logic             is_load;
  logic             is_clr;
  logic             is_shift;

  assign shift_val = {shadow_q[WIDTH-2:0], ser_in};
  assign is_load   = cmd_op == OP_LOAD;
  assign is_clr    = cmd_op == OP_CLEAR;
  assign is_shift  = (cmd_op == OP_SHIFT) && (cmd_data[3:0] != 4'd0);

`ifdef SLE_BANK_CTRL_CHECK_EN
  logic err_q, err_d;
`endif

  // Drive values are launched at the edge before the DRIVE cycle, so the
  // shadow already holds what the bank will capture at the end of it.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    d_d      = '0;
    en_d     = 1'b0;
    sln_d    = 1'b1;
    sd_d     = 1'b0;
    done_d   = 1'b0;
`ifdef SLE_BANK_CTRL_CHECK_EN
    err_d    = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          unique case (1'b1)
            is_load: begin
              state_d  = S_DRIVE;
              d_d      = cmd_data;
              en_d     = 1'b1;
              shadow_d = cmd_data;
              cnt_d    = 4'd0;
            end
            is_clr: begin
              state_d  = S_DRIVE;
              en_d     = 1'b1;
              sln_d    = 1'b0;
              sd_d     = SD_VAL;
              shadow_d = {WIDTH{SD_VAL}};
              cnt_d    = 4'd0;
            end
            is_shift: begin
              state_d  = S_DRIVE;
              d_d      = shift_val;
              en_d     = 1'b1;
              shadow_d = shift_val;
              cnt_d    = cmd_data[3:0] - 4'd1;
            end
            default: begin
              done_d = 1'b1;
`ifdef SLE_BANK_CTRL_CHECK_EN
              err_d  = 1'b0;
`endif
            end
          endcase
        end
      end
      S_DRIVE: begin
        if (cnt_q != 4'd0) begin
          d_d      = shift_val;
          en_d     = 1'b1;
          shadow_d = shift_val;
          cnt_d    = cnt_q - 4'd1;
        end else begin
`ifdef SLE_BANK_CTRL_CHECK_EN
          state_d = S_CHECK;
`else
          state_d = S_IDLE;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef SLE_BANK_CTRL_CHECK_EN
      S_CHECK: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        err_d   = q_in != shadow_q;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge ALn) begin
    if (!ALn) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      cnt_q    <= 4'd0;
      d_q      <= '0;
      en_q     <= 1'b0;
      sln_q    <= 1'b1;
      sd_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      d_q      <= d_d;
      en_q     <= en_d;
      sln_q    <= sln_d;
      sd_q     <= sd_d;
      done_q   <= done_d;
    end
  end

`ifdef SLE_BANK_CTRL_CHECK_EN
  always_ff @(posedge clk or negedge ALn) begin
    if (!ALn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_q_in;
  assign unused_q_in = ^q_in;
  assign err = 1'b0;
`endif

  assign cmd_ready = state_q == S_IDLE;
  assign D         = d_q;
  assign En        = en_q;
  assign SLn       = sln_q;
  assign SD        = sd_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sle_bank_ctrl.sv
// tb_sle_bank_ctrl: directed bench for sle_bank_ctrl with a behavioural
// SLE bank model (optional stuck-at-0 bits) feeding q_in.
module tb_sle_bank_ctrl;

`ifdef SLE_BANK_CTRL_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_SHIFT = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  logic       clk = 1'b0;
  logic       aln = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b11;
  logic [7:0] cmd_data = 8'h00;
  logic       ser_in = 1'b0;
  logic [7:0] q_in;
  logic [7:0] d;
  logic       en;
  logic       sln;
  logic       sd;
  logic       done;
  logic       err;

  logic [7:0] bank_q;
  logic [7:0] stuck = 8'h00;
  int         cyc_n = 0;
  int         t_acc = 0;
  int         n_chk = 0;
  int         n_err = 0;

  sle_bank_ctrl #(.WIDTH(8), .SD_VAL(1'b0)) dut (
    .clk       (clk),
    .ALn       (aln),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .ser_in    (ser_in),
    .q_in      (q_in),
    .D         (d),
    .En        (en),
    .SLn       (sln),
    .SD        (sd),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always_ff @(posedge clk or negedge aln) begin
    if (!aln) bank_q <= 8'h00;
    else if (en) bank_q <= sln ? d : {8{sd}};
  end

  assign q_in = bank_q & ~stuck;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] dat);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = dat;
    @(negedge clk);
    cmd_valid = 1'b0;
    t_acc     = cyc_n - 1;
  endtask

  task automatic wait_done(input string tag, input int exp_lat,
                           input logic exp_err);
    int k;
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " done"}, done, 1);
    chk({tag, " lat"}, cyc_n - t_acc, exp_lat);
    chk({tag, " err"}, err, exp_err);
    chk({tag, " ready"}, cmd_ready, 1);
  endtask

  task automatic pulse_end(input string tag, input logic exp_err);
    @(negedge clk);
    chk({tag, " pulse"}, done, 0);
    chk({tag, " err hold"}, err, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk("rst ready", cmd_ready, 1);
    chk("rst en", en, 0);
    chk("rst sln", sln, 1);
    chk("rst sd", sd, 0);
    chk("rst d", d, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    aln = 1'b1;
    @(negedge clk);

    // LOAD then CLEAR
    send(OP_LOAD, 8'hA5);
    chk("load en", en, 1);
    chk("load d", d, 8'hA5);
    chk("load sln", sln, 1);
    chk("load ready", cmd_ready, 0);
    @(negedge clk);
    chk("load en off", en, 0);
    wait_done("load", 2 + CHK, 1'b0);
    pulse_end("load", 1'b0);
    send(OP_CLEAR, 8'hFF);
    chk("clr en", en, 1);
    chk("clr sln", sln, 0);
    chk("clr sd", sd, 0);
    chk("clr d", d, 0);
    @(negedge clk);
    chk("clr sln off", sln, 1);
    wait_done("clr", 2 + CHK, 1'b0);
    pulse_end("clr", 1'b0);

    // SHIFT from 0x81
    send(OP_LOAD, 8'h81);
    wait_done("ld81", 2 + CHK, 1'b0);
    @(negedge clk);
    ser_in = 1'b1;
    send(OP_SHIFT, 8'h03);
    chk("sh d0", d, 8'h03);
    chk("sh en0", en, 1);
    ser_in = 1'b0;
    @(negedge clk);
    chk("sh d1", d, 8'h06);
    ser_in = 1'b1;
    @(negedge clk);
    chk("sh d2", d, 8'h0D);
    ser_in = 1'b0;
    @(negedge clk);
    chk("sh en off", en, 0);
    wait_done("shift", 4 + CHK, 1'b0);
    pulse_end("shift", 1'b0);

    // zero count and NOP
    send(OP_SHIFT, 8'hF0);
    chk("sh0 en", en, 0);
    wait_done("sh0", 1, 1'b0);
    pulse_end("sh0", 1'b0);
    send(OP_NOP, 8'h5A);
    chk("nop en", en, 0);
    wait_done("nop", 1, 1'b0);
    pulse_end("nop", 1'b0);

    // held valid: second command only taken in the done cycle
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    cmd_data  = 8'h11;
    @(negedge clk);
    t_acc = cyc_n - 1;
    chk("hold en", en, 1);
    chk("hold d", d, 8'h11);
    chk("hold ready", cmd_ready, 0);
    cmd_data = 8'h22;
    wait_done("hold1", 2 + CHK, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0;
    t_acc = cyc_n - 1;
    chk("b2b en", en, 1);
    chk("b2b d", d, 8'h22);
    chk("b2b done", done, 0);
    wait_done("b2b", 2 + CHK, 1'b0);
    pulse_end("b2b", 1'b0);

    // readback mismatch on stuck bit 3
    stuck = 8'h08;
    send(OP_LOAD, 8'hFF);
    wait_done("mis", 2 + CHK, CHK[0]);
    pulse_end("mis", CHK[0]);
    send(OP_LOAD, 8'h00);
    wait_done("mis ok", 2 + CHK, 1'b0);
    pulse_end("mis ok", 1'b0);
    send(OP_LOAD, 8'h3C);
    wait_done("ld3c", 2 + CHK, CHK[0]);
    pulse_end("ld3c", CHK[0]);
    stuck = 8'h00;

    // reset in the 4th DRIVE cycle of a 15-step shift
    ser_in = 1'b1;
    send(OP_SHIFT, 8'h0F);
    repeat (3) @(negedge clk);
    chk("rst4 en pre", en, 1);
    aln = 1'b0;
    #1;
    chk("rst4 en", en, 0);
    chk("rst4 d", d, 0);
    chk("rst4 ready", cmd_ready, 1);
    chk("rst4 sln", sln, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst4 done", done, 0);
    end
    aln = 1'b1;
    ser_in = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("rst4 no done", done, 0);
    end
    send(OP_LOAD, 8'h5A);
    chk("rst4 ld d", d, 8'h5A);
    wait_done("rst4 ld", 2 + CHK, 1'b0);
    pulse_end("rst4 ld", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
